// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and default width for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply (LSB first) or restoring divide (MSB first).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               div_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               qbit_o
);
  logic [WIDTH-1:0] add_a, add_b, sum;
  logic             cout;

  // Divide: shifted remainder minus divisor. Multiply: upper half plus gated multiplicand.
  assign add_a = div_i ? acc_i[2*WIDTH-2:WIDTH-1] : acc_i[2*WIDTH-1:WIDTH];
  assign add_b = div_i ? ~opnd_i : (acc_i[0] ? opnd_i : '0);

  ripple_adder32 u_add (
    .a_i   (add_a),
    .b_i   (add_b),
    .cin_i (div_i),
    .sum_o (sum),
    .cout_o(cout)
  );

  // A set remainder MSB means the shifted value exceeds any divisor.
  assign qbit_o = div_i & (acc_i[2*WIDTH-1] | cout);

  always_comb begin
    if (div_i)
      acc_o = {(qbit_o ? sum : add_a), acc_i[WIDTH-2:0], 1'b0};
    else
      acc_o = {cout, sum, acc_i[WIDTH-1:1]};
  end
endmodule

// File: rtl/ripple_adder32.sv
// Plain 32-bit ripple-carry adder shared by the execute-stage datapaths.
module ripple_adder32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);
  logic [32:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign sum_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]    = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[32];
endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: MULT/MULTU/DIV/DIVU over WIDTH cycles plus a sign-fix cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  state_t             state_q;
  logic [2:0]         op_q;
  logic [2*WIDTH-1:0] acc_q, acc_d, step_acc;
  logic [WIDTH-1:0]   opnd_q, araw_q, hi_q, lo_q;
  logic [CW-1:0]      cnt_q;
  logic               neg_res_q, neg_rem_q, div0_q, busy_q, done_q;
  logic               qbit, div_q;

  logic               is_sgn, is_div_in, is_iter, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, fix_hi_d, fix_lo_d;
  logic [2*WIDTH-1:0] prod;

  assign div_q = (op_q == OP_DIV) || (op_q == OP_DIVU);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i (acc_q),
    .opnd_i(opnd_q),
    .div_i (div_q),
    .acc_o (step_acc),
    .qbit_o(qbit)
  );

  assign acc_d = step_acc | {{(2*WIDTH-1){1'b0}}, qbit};

  always_comb begin
    is_sgn    = (op == OP_MULT) || (op == OP_DIV);
    is_div_in = (op == OP_DIV)  || (op == OP_DIVU);
    is_iter   = (op == OP_MULT) || (op == OP_MULTU) || is_div_in;
    a_neg     = is_sgn & a[WIDTH-1];
    b_neg     = is_sgn & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;

    prod      = neg_res_q ? -acc_q : acc_q;
    fix_hi_d  = prod[2*WIDTH-1:WIDTH];
    fix_lo_d  = prod[WIDTH-1:0];
    if (div_q) begin
      // Divide by zero reports the raw dividend and an all-ones quotient, unsigned.
      if (div0_q) begin
        fix_hi_d = araw_q;
        fix_lo_d = '1;
      end else begin
        fix_hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        fix_lo_d = neg_res_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      araw_q    <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start && is_iter) begin
            op_q      <= op;
            acc_q     <= {{WIDTH{1'b0}}, is_div_in ? a_mag : b_mag};
            opnd_q    <= is_div_in ? b_mag : a_mag;
            araw_q    <= a;
            div0_q    <= is_div_in && (b == '0);
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_CALC;
          end else if (start && op == OP_MTHI) begin
            hi_q <= a;
          end else if (start && op == OP_MTLO) begin
            lo_q <= a;
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          hi_q    <= fix_hi_d;
          lo_q    <= fix_lo_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit: latency, results, MTHI/MTLO and reset abort.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  typedef struct {
    string      tag;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0]   op = '0;
  logic         start = 1'b0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic [W-1:0] hi_m = '0, lo_m = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .op   (op),
    .start(start),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue an iterative op, then step through the fixed latency checking busy/done and held HI/LO.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    exp_t e;
    int   busy_bad, done_bad;
    sb.push_back('{tag, ehi, elo});
    op = o; a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    op = OP_MTHI; a = $urandom; b = $urandom;
    busy_bad = 0; done_bad = 0;
    for (int c = 1; c <= W + 1; c++) begin
      if (busy !== 1'b1) busy_bad++;
      if (done !== 1'b0) done_bad++;
      if (c == W + 1) begin
        chk({tag, " hi held"}, hi, hi_m);
        chk({tag, " lo held"}, lo, lo_m);
      end
      tick();
    end
    chk({tag, " busy low cycles"}, W'(busy_bad), '0);
    chk({tag, " early done"}, W'(done_bad), '0);
    chk({tag, " done"}, W'(done), W'(1));
    chk({tag, " busy end"}, W'(busy), '0);
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, W'(1), '0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, " hi"}, hi, e.hi);
      chk({e.tag, " lo"}, lo, e.lo);
      hi_m = e.hi; lo_m = e.lo;
    end
    op = '0;
  endtask

  initial begin
    int bad;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset hi", hi, '0);
    chk("reset lo", lo, '0);
    chk("reset busy", W'(busy), '0);
    chk("reset done", W'(done), '0);

    run_op("mult -3*5",     OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu max",     OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div -7/2",      OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div overflow",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
    run_op("divu 7/0",      OP_DIVU,  32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF);
    run_op("divu 100/7",    OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14);
    run_op("div -7/0",      OP_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div 7/-2",      OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);

    // Abort: MTHI during CALC is ignored, reset at cycle 10 clears everything.
    op = OP_MULT; a = 32'd9; b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    op = OP_MTHI; a = 32'hDEAD_BEEF; start = 1'b1;
    tick();
    start = 1'b0; op = '0;
    chk("mthi ignored in calc", hi, hi_m);
    chk("busy mid calc", W'(busy), W'(1));
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hi_m = '0; lo_m = '0;
    chk("abort busy", W'(busy), '0);
    chk("abort hi", hi, '0);
    chk("abort lo", lo, '0);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) bad++;
      tick();
    end
    chk("no done after abort", W'(bad), '0);

    op = OP_MTHI; a = 32'h1234_5678; start = 1'b1;
    tick();
    chk("mthi hi", hi, 32'h1234_5678);
    chk("mthi busy", W'(busy), '0);
    op = OP_MTLO; a = 32'h9ABC_DEF0;
    tick();
    start = 1'b0; op = '0;
    chk("mtlo lo", lo, 32'h9ABC_DEF0);
    chk("mtlo hi kept", hi, 32'h1234_5678);
    chk("mtlo busy", W'(busy), '0);
    chk("mtlo done", W'(done), '0);
    hi_m = 32'h1234_5678; lo_m = 32'h9ABC_DEF0;

    op = 3'd7; a = 32'h5555_5555; start = 1'b1;
    tick();
    start = 1'b0; op = '0;
    chk("op7 busy", W'(busy), '0);
    chk("op7 hi", hi, hi_m);

    // run_op returns on the done cycle, so consecutive calls are back-to-back.
    run_op("multu 3*4 a",   OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);
    run_op("multu 3*4 b2b", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative HI/LO multiply/divide unit for the execute stage. It sits beside the 32-bit ALU and takes the same rs/rt operands. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI/LO registers that the writeback mux reads for MFHI/MFLO. The control unit stalls the PC while `busy` is high.

## Interface

Parameters:
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a`  in  WIDTH  first operand (rs); dividend or multiplicand.
- `b`  in  WIDTH  second operand (rt); divisor or multiplier.
- `op`  in  3  operation code:
  - 3'd1 MULT, 3'd2 MULTU, 3'd3 DIV, 3'd4 DIVU, 3'd5 MTHI, 3'd6 MTLO.
  - 0 and 7 are no-ops.
- `start`  in  1  request; sampled only in IDLE.
- `busy`  out  1  high while an iterative operation is in progress.
- `done`  out  1  one-cycle pulse when new HI/LO values become visible.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation

- States: IDLE, CALC, FIX.
- IDLE with `start` and MULT, MULTU, DIV or DIVU:
  - Latch `op`.
  - Latch magnitudes of `a` and `b` (absolute value for signed ops, raw for unsigned).
  - Latch the result-sign flags.
  - Clear the iteration counter, then go to CALC.
- IDLE with `start` and MTHI/MTLO: write `a` into `hi`/`lo` at that edge and stay in IDLE. No `busy`, no `done`.
- IDLE with `start` and op 0/7: ignored.
- CALC, multiply: shift-add, one multiplier bit per cycle, LSB first, into a 2·WIDTH accumulator.
- CALC, divide: restoring division, one quotient bit per cycle, MSB first.
  - Trial subtract remainder − divisor.
  - Keep the result if it is non-negative.
- CALC runs for exactly `WIDTH` cycles, then goes to FIX.
- FIX, multiply: negate the 2·WIDTH product if the operand signs differ (signed only). HI = upper half, LO = lower half.
- FIX, divide:
  - LO = quotient, negated if the operand signs differ.
  - HI = remainder, negated if the dividend was negative (remainder takes the dividend's sign).
- FIX writes HI/LO, then returns to IDLE.
- Divide by zero keeps the full latency. Result: LO = all ones, HI = original `a`, with no sign fix.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0 (natural two's-complement wrap).
- `start` while not in IDLE is ignored; operands are not re-sampled.
- Changes on `a`, `b` or `op` after the start cycle have no effect.
- `hi`/`lo` hold their previous values throughout CALC and FIX until the FIX edge.

## Timing

- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, state IDLE.
- `rst` asserted mid-operation aborts at that edge:
  - All outputs take their reset values on the next cycle.
  - A `start` coincident with `rst` is dropped.
- Iterative op, with the start edge at cycle 0:
  - `busy` = 1 in cycles 1 through WIDTH+1 (CALC ×WIDTH, FIX ×1).
  - Cycle WIDTH+2: `busy` = 0, `done` = 1, `hi`/`lo` show the new result. This is cycle 34 for WIDTH = 32.
  - A new `start` is accepted in cycle WIDTH+2 (back-to-back).
- MTHI/MTLO: new value visible the cycle after the start edge. Zero-latency stall.
- `busy` and `done` are registered outputs (no combinational path from inputs).

## Structure

- Package `muldiv_pkg` holds:
  - op-code localparams `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`, `OP_MTHI`, `OP_MTLO`;
  - state encoding `ST_IDLE`, `ST_CALC`, `ST_FIX`;
  - the default `WIDTH`.
- One sub-module, `muldiv_step`: purely combinational single-iteration datapath. It takes accumulator/remainder, operand and mode, and returns the next accumulator/remainder plus the quotient bit.
- `muldiv_step` builds its add and subtract from the existing `ripple_adder32`.
- The FSM, counter, sign handling and HI/LO registers live in `muldiv_unit`.

## Test plan

- MULT a=0xFFFFFFFD (−3), b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; `done` exactly at cycle 34, `busy` high for cycles 1–33.
- MULTU a=b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU a=7, b=0 → LO=0xFFFFFFFF, HI=7 after 34 cycles. DIVU a=100, b=7 → LO=14, HI=2.
- MULT started; at cycle 5 pulse `start` with MTHI (ignored); at cycle 10 assert `rst` → cycle 11 `busy`=0, `hi`=`lo`=0; no `done` pulse ever.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 on consecutive cycles → `hi`/`lo` updated one cycle after each, `busy` never asserted. Then back-to-back MULTU 3×4 issued on its `done` cycle → LO=12, HI=0.
